spi_ram_arbiter: RTL
====================

Name: spi_ram_arbiter

Overview:
- Sits between the SPI slave and the single-port RAM.
- Decodes SPI command words (rx_data/rx_valid) into RAM accesses and returns read data on tx_data/tx_valid.
- Shares the one RAM port with a local host requester using round-robin arbitration.
- Only block that drives RAM control; the RAM sees at most one access per cycle.

Parameters:
ADDR_SIZE, 8, RAM address width
DATA_W, 8, RAM data width; SPI payload is rx_data[7:0], so fixed at 8

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
rx_data  in  10  SPI command word; [9:8] opcode, [7:0] payload
rx_valid  in  1  SPI word valid, one-cycle pulse
tx_data  out  8  read data to SPI slave
tx_valid  out  1  tx_data valid (level)
spi_drop  out  1  one-cycle pulse: SPI command discarded
h_req  in  1  host request; held with fields stable until h_gnt
h_we  in  1  host write(1)/read(0)
h_addr  in  ADDR_SIZE  host address
h_wdata  in  8  host write data
h_gnt  out  1  one-cycle pulse: host access issued this cycle
h_rdata  out  8  host read data
h_rvalid  out  1  one-cycle pulse: h_rdata valid
ram_addr  out  ADDR_SIZE  RAM address
ram_din  out  8  RAM write data
ram_we  out  1  RAM write enable
ram_re  out  1  RAM read enable; ram_dout valid next cycle
ram_dout  in  8  RAM registered read data

Behaviour:
- Reset (rst=1 at edge): state IDLE; all outputs 0; wr_addr, rd_addr, spi_pend cleared; last_grant=HOST. Any in-flight access is abandoned: no h_rvalid/tx_valid, ram_we/ram_re low next cycle.
- SPI opcode decode on rx_valid:
  - 00: wr_addr <= payload; no RAM access.
  - 10: rd_addr <= payload; no RAM access.
  - 01: write payload to wr_addr; sets spi_pend.
  - 11: read rd_addr, payload ignored; sets spi_pend.
  - 00/10 are accepted even while spi_pend=1.
- spi_pend is one deep. An 01/11 word arriving while spi_pend=1, or in the cycle spi_pend is being consumed, is discarded and spi_drop pulses the next cycle. The pending command is unaffected.
- Any rx_valid clears tx_valid next cycle. If tx_data is being delivered in that same cycle, delivery wins and tx_valid=1.
- FSM states: IDLE, ACCESS, READ_WAIT.
  - IDLE: samples spi_pend and h_req.
    - One request: grant it.
    - Both: grant the side not in last_grant.
    - Set last_grant; go to ACCESS.
    - None: stay.
  - ACCESS (1 cycle): drive ram_addr.
    - Write: ram_we=1 and ram_din, then go to IDLE.
    - Read: ram_re=1, then go to READ_WAIT.
    - Host grant: h_gnt=1 this cycle.
    - SPI grant: spi_pend cleared at end of cycle.
  - READ_WAIT (1 cycle): capture ram_dout.
    - SPI: tx_data <= ram_dout, tx_valid=1 from the next cycle.
    - Host: h_rdata <= ram_dout, h_rvalid=1 next cycle for one cycle.
    - Then go to IDLE.
- Latency:
  - SPI rx_valid at cycle N: ACCESS at N+2; SPI read gives tx_valid at N+4.
  - h_req seen in IDLE at cycle M: h_gnt/ACCESS at M+1; read gives h_rvalid at M+3.
- Throughput: write needs 2 cycles per access, read needs 3; ram_we and ram_re are never both high.
- Outside ACCESS, ram_we and ram_re are 0; ram_addr and ram_din hold their last values.
- Host must hold h_req until h_gnt. If it deasserts h_req before grant, nothing is issued. h_req still high the cycle after h_gnt counts as a new request.
- Address width rule: SPI payload is zero-extended or truncated to ADDR_SIZE.

Test Plan:
- SPI write then read: rx 0x0_12 (00), 0x1_A5 (01), 0x2_12 (10), 0x3_00 (11) -> ram_we at addr 0x12 with din 0xA5; ram_re at 0x12; tx_data=0xA5, tx_valid=1 four cycles after the 11 word.
- Host read alone: h_req=1, h_we=0, h_addr=0x40, RAM holds 0x3C -> h_gnt at M+1, ram_re at M+1, h_rvalid pulse with h_rdata=0x3C at M+3.
- Contention: spi_pend (write 0x77 @0x05) and host write (0x99 @0x06) both pending in IDLE after reset -> SPI first (last_grant=HOST), host next; then repeat -> host first.
- Overflow: two 01 words with no gap while host holds RAM -> first written, second discarded; spi_drop one cycle; RAM gets only the first data.
- tx_valid clear: after tx_valid=1, rx 0x0_00 -> tx_valid 0 next cycle, tx_data unchanged.
- Reset mid-read: rst=1 in READ_WAIT -> no tx_valid/h_rvalid, state IDLE, ram_re=0, spi_pend=0; then a fresh write completes normally.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_arbiter
// Purpose  : Decodes SPI command words into RAM accesses and round-robins the
//            single RAM port between the SPI side and a local host.
// Revision : 1.0 - initial release
// ============================================================================
module spi_ram_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    output logic [DATA_W-1:0]    tx_data,
    output logic                 tx_valid,
    output logic                 spi_drop,
    input  logic                 h_req,
    input  logic                 h_we,
    input  logic [ADDR_SIZE-1:0] h_addr,
    input  logic [DATA_W-1:0]    h_wdata,
    output logic                 h_gnt,
    output logic [DATA_W-1:0]    h_rdata,
    output logic                 h_rvalid,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [DATA_W-1:0]    ram_din,
    output logic                 ram_we,
    output logic                 ram_re,
    input  logic [DATA_W-1:0]    ram_dout
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_ACCESS    = 2'd1;
    localparam logic [1:0] c_READ_WAIT = 2'd2;

    localparam logic [1:0] c_OP_SET_WA = 2'b00;
    localparam logic [1:0] c_OP_WRITE  = 2'b01;
    localparam logic [1:0] c_OP_SET_RA = 2'b10;
    localparam logic [1:0] c_OP_READ   = 2'b11;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic                 w_grant_spi;
    logic                 w_grant_host;

    logic [ADDR_SIZE-1:0] w_payload_addr;
    logic [DATA_W-1:0]    w_payload_data;

    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic                 r_spi_pend;
    logic                 r_pend_we;
    logic [ADDR_SIZE-1:0] r_pend_addr;
    logic [DATA_W-1:0]    r_pend_data;
    logic                 r_last_host;
    logic                 r_owner_host;

    logic [ADDR_SIZE-1:0] r_ram_addr;
    logic [DATA_W-1:0]    r_ram_din;
    logic                 r_ram_we;
    logic                 r_ram_re;
    logic                 r_h_gnt;
    logic [DATA_W-1:0]    r_h_rdata;
    logic                 r_h_rvalid;
    logic [DATA_W-1:0]    r_tx_data;
    logic                 r_tx_valid;
    logic                 r_spi_drop;

    generate
        if (ADDR_SIZE > 8) begin : g_addr_zext
            assign w_payload_addr = {{(ADDR_SIZE-8){1'b0}}, rx_data[7:0]};
        end else begin : g_addr_trunc
            assign w_payload_addr = rx_data[ADDR_SIZE-1:0];
        end
    endgenerate

    assign w_payload_data = rx_data[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // On contention the side that did not win last time gets the port.
    always_comb begin
        w_next_state = r_state;
        w_grant_spi  = 1'b0;
        w_grant_host = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (r_spi_pend && h_req) begin
                    w_grant_spi  = r_last_host;
                    w_grant_host = !r_last_host;
                end else begin
                    w_grant_spi  = r_spi_pend;
                    w_grant_host = h_req;
                end
                if (w_grant_spi || w_grant_host) begin
                    w_next_state = c_ACCESS;
                end
            end
            c_ACCESS:    w_next_state = r_ram_re ? c_READ_WAIT : c_IDLE;
            c_READ_WAIT: w_next_state = c_IDLE;
            default:     w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_spi_pend   <= 1'b0;
            r_pend_we    <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
            r_last_host  <= 1'b1;
            r_owner_host <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_ram_we     <= 1'b0;
            r_ram_re     <= 1'b0;
            r_h_gnt      <= 1'b0;
            r_h_rdata    <= '0;
            r_h_rvalid   <= 1'b0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_spi_drop   <= 1'b0;
        end else begin
            r_ram_we   <= 1'b0;
            r_ram_re   <= 1'b0;
            r_h_gnt    <= 1'b0;
            r_h_rvalid <= 1'b0;
            r_spi_drop <= 1'b0;

            // RAM controls are registered on the IDLE->ACCESS edge.
            if (w_grant_spi) begin
                r_ram_addr   <= r_pend_addr;
                r_ram_we     <= r_pend_we;
                r_ram_re     <= !r_pend_we;
                r_owner_host <= 1'b0;
                r_last_host  <= 1'b0;
                if (r_pend_we) begin
                    r_ram_din <= r_pend_data;
                end
            end else if (w_grant_host) begin
                r_ram_addr   <= h_addr;
                r_ram_we     <= h_we;
                r_ram_re     <= !h_we;
                r_h_gnt      <= 1'b1;
                r_owner_host <= 1'b1;
                r_last_host  <= 1'b1;
                if (h_we) begin
                    r_ram_din <= h_wdata;
                end
            end

            if (r_state == c_ACCESS && !r_owner_host) begin
                r_spi_pend <= 1'b0;
            end

            // spi_pend is still set during its consuming ACCESS, so one test covers both drop cases.
            if (rx_valid) begin
                case (rx_data[9:8])
                    c_OP_SET_WA: r_wr_addr <= w_payload_addr;
                    c_OP_SET_RA: r_rd_addr <= w_payload_addr;
                    c_OP_WRITE, c_OP_READ: begin
                        if (r_spi_pend) begin
                            r_spi_drop <= 1'b1;
                        end else begin
                            r_spi_pend  <= 1'b1;
                            r_pend_we   <= (rx_data[9:8] == c_OP_WRITE);
                            r_pend_addr <= (rx_data[9:8] == c_OP_WRITE) ? r_wr_addr : r_rd_addr;
                            r_pend_data <= w_payload_data;
                        end
                    end
                    default: ;
                endcase
            end

            if (r_state == c_READ_WAIT && !r_owner_host) begin
                r_tx_data  <= ram_dout;
                r_tx_valid <= 1'b1;
            end else if (rx_valid) begin
                r_tx_valid <= 1'b0;
            end

            if (r_state == c_READ_WAIT && r_owner_host) begin
                r_h_rdata  <= ram_dout;
                r_h_rvalid <= 1'b1;
            end
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign spi_drop = r_spi_drop;
    assign h_gnt    = r_h_gnt;
    assign h_rdata  = r_h_rdata;
    assign h_rvalid = r_h_rvalid;
    assign ram_addr = r_ram_addr;
    assign ram_din  = r_ram_din;
    assign ram_we   = r_ram_we;
    assign ram_re   = r_ram_re;

endmodule
`default_nettype wire
